header_field_extractor: RTL and testbench

//  Consumes one captured packet header (flat byte vector plus length) per valid/ready transfer from the header buffer.

---
 rtl/header_field_extractor.sv | 250 +++++++++++++++++++++++++
 tb/tb_header_field_extractor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_field_extractor.sv
// header_field_extractor
//   Parses one captured packet header per valid/ready transfer: Ethernet (optionally 802.1Q),
//   IPv4 addresses/protocol, TCP/UDP ports, and verifies the IPv4 header checksum one 16-bit
//   word per cycle. One registered result per packet is held until downstream accepts it.
//   Optional feature macro: HFE_VLAN_EN (802.1Q tag decode; default build ignores tags).
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   hdr_flat/hdr_len      captured header bytes (byte 0 = bits [7:0]) and packet length
//   hdr_valid/hdr_ready   header handshake (ready only while idle)
//   parse_valid/ready     result handshake
//   eth_type .. malformed parsed fields and status flags
module header_field_extractor #(
  parameter int unsigned HEADER_BYTES = 192,
  parameter int unsigned PTR_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [8*HEADER_BYTES-1:0] hdr_flat,
  input  logic [PTR_W:0]            hdr_len,
  input  logic                      hdr_valid,
  output logic                      hdr_ready,
  output logic                      parse_valid,
  input  logic                      parse_ready,
  output logic [15:0]               eth_type,
  output logic [11:0]               vlan_id,
  output logic [31:0]               src_ip,
  output logic [31:0]               dst_ip,
  output logic [7:0]                ip_proto,
  output logic [15:0]               src_port,
  output logic [15:0]               dst_port,
  output logic [PTR_W:0]            pkt_len,
  output logic                      is_ipv4,
  output logic                      is_l4,
  output logic                      csum_ok,
  output logic                      malformed
);

  localparam int unsigned HdrW = 8 * HEADER_BYTES;

  typedef enum logic [2:0] {StIdle, StEth, StCsum, StL4, StDone} state_e;

  state_e          state_q, state_d;
  logic [HdrW-1:0] hdr_q, hdr_d;
  logic [PTR_W:0]  len_q, len_d;
  logic [4:0]      l3_off_q, l3_off_d;
  logic [3:0]      ihl_q, ihl_d;
  logic [4:0]      word_q, word_d;
  logic [15:0]     acc_q, acc_d;

  logic [15:0]     eth_type_q, eth_type_d;
  logic [11:0]     vlan_id_q, vlan_id_d;
  logic [31:0]     src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [7:0]      ip_proto_q, ip_proto_d;
  logic [15:0]     src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic [PTR_W:0]  pkt_len_q, pkt_len_d;
  logic            is_ipv4_q, is_ipv4_d, is_l4_q, is_l4_d;
  logic            csum_ok_q, csum_ok_d, malformed_q, malformed_d;

  function automatic logic [7:0] get_byte(input logic [HdrW-1:0] v, input int unsigned idx);
    return v[idx*8 +: 8];
  endfunction

  // Big-endian 16-bit field starting at byte idx
  function automatic logic [15:0] get_word(input logic [HdrW-1:0] v, input int unsigned idx);
    return {get_byte(v, idx), get_byte(v, idx + 1)};
  endfunction

  always_comb begin
    logic [15:0] etype;
    logic [11:0] vid_n;
    logic [7:0]  vbyte;
    logic [16:0] sum;
    logic [15:0] acc_n;
    int unsigned l3, l4, min_len, len_int, len_eff;

    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    l3_off_d    = l3_off_q;
    ihl_d       = ihl_q;
    word_d      = word_q;
    acc_d       = acc_q;
    eth_type_d  = eth_type_q;
    vlan_id_d   = vlan_id_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    ip_proto_d  = ip_proto_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;
    pkt_len_d   = pkt_len_q;
    is_ipv4_d   = is_ipv4_q;
    is_l4_d     = is_l4_q;
    csum_ok_d   = csum_ok_q;
    malformed_d = malformed_q;

    etype   = get_word(hdr_q, 12);
    vid_n   = '0;
    l3      = 14;
    min_len = 14;
    vbyte   = '0;
    len_int = 32'(len_q);
    // Only bytes actually captured in the buffer may be parsed
    len_eff = (len_int < HEADER_BYTES) ? len_int : HEADER_BYTES;
    sum     = {1'b0, acc_q} + {1'b0, get_word(hdr_q, 32'(l3_off_q) + 2 * 32'(word_q))};
    // End-around carry folded back in every word
    acc_n   = sum[15:0] + {15'b0, sum[16]};
    l4      = 32'(l3_off_q) + 4 * 32'(ihl_q);

    unique case (state_q)
      StIdle: begin
        if (hdr_valid) begin
          hdr_d       = hdr_flat;
          len_d       = hdr_len;
          eth_type_d  = '0;
          vlan_id_d   = '0;
          src_ip_d    = '0;
          dst_ip_d    = '0;
          ip_proto_d  = '0;
          src_port_d  = '0;
          dst_port_d  = '0;
          pkt_len_d   = hdr_len;
          is_ipv4_d   = 1'b0;
          is_l4_d     = 1'b0;
          csum_ok_d   = 1'b0;
          malformed_d = 1'b0;
          state_d     = StEth;
        end
      end
      StEth: begin
        state_d = StDone;
`ifdef HFE_VLAN_EN
        begin : vlan_decode
          logic [15:0] tci;
          tci = get_word(hdr_q, 14);
          if (len_int >= 14 && etype == 16'h8100) begin
            vid_n   = tci[11:0];
            etype   = get_word(hdr_q, 16);
            l3      = 18;
            min_len = 18;
          end
        end
`endif
        if (len_int < min_len) begin
          malformed_d = 1'b1;
        end else begin
          eth_type_d = etype;
          vlan_id_d  = vid_n;
          if (etype == 16'h0800) begin
            vbyte = get_byte(hdr_q, l3);
            if (vbyte[7:4] != 4'd4 || vbyte[3:0] < 4'd5 ||
                l3 + 4 * 32'(vbyte[3:0]) > len_eff) begin
              malformed_d = 1'b1;
            end else begin
              src_ip_d   = {get_word(hdr_q, l3 + 12), get_word(hdr_q, l3 + 14)};
              dst_ip_d   = {get_word(hdr_q, l3 + 16), get_word(hdr_q, l3 + 18)};
              ip_proto_d = get_byte(hdr_q, l3 + 9);
              is_ipv4_d  = 1'b1;
              l3_off_d   = 5'(l3);
              ihl_d      = vbyte[3:0];
              acc_d      = '0;
              word_d     = '0;
              state_d    = StCsum;
            end
          end
        end
      end
      StCsum: begin
        acc_d  = acc_n;
        word_d = word_q + 5'd1;
        if (word_q == {ihl_q, 1'b0} - 5'd1) begin
          csum_ok_d = (acc_n == 16'hFFFF);
          state_d   = StL4;
        end
      end
      StL4: begin
        if ((ip_proto_q == 8'd6 || ip_proto_q == 8'd17) && l4 + 4 <= len_int) begin
          src_port_d = get_word(hdr_q, l4);
          dst_port_d = get_word(hdr_q, l4 + 2);
          is_l4_d    = 1'b1;
        end
        state_d = StDone;
      end
      StDone: begin
        if (parse_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hdr_q       <= '0;
      len_q       <= '0;
      l3_off_q    <= '0;
      ihl_q       <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      eth_type_q  <= '0;
      vlan_id_q   <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      ip_proto_q  <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      pkt_len_q   <= '0;
      is_ipv4_q   <= 1'b0;
      is_l4_q     <= 1'b0;
      csum_ok_q   <= 1'b0;
      malformed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      l3_off_q    <= l3_off_d;
      ihl_q       <= ihl_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      eth_type_q  <= eth_type_d;
      vlan_id_q   <= vlan_id_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      ip_proto_q  <= ip_proto_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
      pkt_len_q   <= pkt_len_d;
      is_ipv4_q   <= is_ipv4_d;
      is_l4_q     <= is_l4_d;
      csum_ok_q   <= csum_ok_d;
      malformed_q <= malformed_d;
    end
  end

  // Handshake flags decode straight from the state register
  assign hdr_ready   = (state_q == StIdle);
  assign parse_valid = (state_q == StDone);
  assign eth_type    = eth_type_q;
  assign vlan_id     = vlan_id_q;
  assign src_ip      = src_ip_q;
  assign dst_ip      = dst_ip_q;
  assign ip_proto    = ip_proto_q;
  assign src_port    = src_port_q;
  assign dst_port    = dst_port_q;
  assign pkt_len     = pkt_len_q;
  assign is_ipv4     = is_ipv4_q;
  assign is_l4       = is_l4_q;
  assign csum_ok     = csum_ok_q;
  assign malformed   = malformed_q;

endmodule

// File: tb/tb_header_field_extractor.sv
module tb_header_field_extractor;
  localparam int HB = 192;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8*HB-1:0] hdr_flat;
  logic [8:0]      hdr_len;
  logic            hdr_valid, hdr_ready, parse_valid, parse_ready;
  logic [15:0]     eth_type, src_port, dst_port;
  logic [11:0]     vlan_id;
  logic [31:0]     src_ip, dst_ip;
  logic [7:0]      ip_proto;
  logic [8:0]      pkt_len;
  logic            is_ipv4, is_l4, csum_ok, malformed;

  header_field_extractor #(.HEADER_BYTES(HB), .PTR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hdr_flat(hdr_flat), .hdr_len(hdr_len),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .parse_valid(parse_valid),
    .parse_ready(parse_ready), .eth_type(eth_type), .vlan_id(vlan_id), .src_ip(src_ip),
    .dst_ip(dst_ip), .ip_proto(ip_proto), .src_port(src_port), .dst_port(dst_port),
    .pkt_len(pkt_len), .is_ipv4(is_ipv4), .is_l4(is_l4), .csum_ok(csum_ok),
    .malformed(malformed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] et;  logic [11:0] vid; logic [31:0] sip; logic [31:0] dip;
    logic [7:0]  pr;  logic [15:0] sp;  logic [15:0] dp;  logic [8:0]  pl;
    logic v4; logic l4; logic ck; logic mf; int lat;
  } exp_t;

  typedef struct {
    logic [8*HB-1:0] flat;
    logic [8:0]      len;
    exp_t            e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[$];
  logic [7:0] pb [HB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] et, input logic [11:0] vid,
                                  input logic [31:0] sip, input logic [31:0] dip,
                                  input logic [7:0] pr, input logic [15:0] sp,
                                  input logic [15:0] dp, input logic [8:0] pl,
                                  input logic v4, input logic l4, input logic ck,
                                  input logic mf, input int lat);
    exp_t e;
    e.et = et; e.vid = vid; e.sip = sip; e.dip = dip; e.pr = pr; e.sp = sp; e.dp = dp;
    e.pl = pl; e.v4 = v4; e.l4 = l4; e.ck = ck; e.mf = mf; e.lat = lat;
    return e;
  endfunction

  task automatic put16(input int off, input logic [15:0] v);
    pb[off]     = v[15:8];
    pb[off + 1] = v[7:0];
  endtask

  task automatic new_frame(input logic [15:0] etype);
    for (int i = 0; i < HB; i++) pb[i] = 8'h00;
    for (int i = 0; i < 12; i++) pb[i] = 8'(i + 1);
    put16(12, etype);
  endtask

  // IPv4 header 10.0.0.1 -> 10.0.0.2 with a correct checksum, then L4 ports
  task automatic build_ip(input int l3, input logic [7:0] vihl, input logic [7:0] proto,
                          input logic [15:0] sp, input logic [15:0] dp);
    int ihl;
    int sum;
    ihl = int'(vihl[3:0]);
    pb[l3] = vihl;
    put16(l3 + 2, 16'(4 * ihl + 8));
    pb[l3 + 8]  = 8'd64;
    pb[l3 + 9]  = proto;
    put16(l3 + 12, 16'h0a00); put16(l3 + 14, 16'h0001);
    put16(l3 + 16, 16'h0a00); put16(l3 + 18, 16'h0002);
    for (int i = 20; i < 4 * ihl; i++) pb[l3 + i] = 8'h01;
    put16(l3 + 10, 16'h0000);
    sum = 0;
    for (int i = 0; i < 4 * ihl; i += 2) sum += 32'({pb[l3 + i], pb[l3 + i + 1]});
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    put16(l3 + 10, ~16'(sum));
    put16(l3 + 4 * ihl, sp);
    put16(l3 + 4 * ihl + 2, dp);
  endtask

  function automatic logic [8*HB-1:0] pack();
    logic [8*HB-1:0] f;
    for (int i = 0; i < HB; i++) f[i*8 +: 8] = pb[i];
    return f;
  endfunction

  task automatic add_vec(input logic [8:0] len, input exp_t e);
    vec_t v;
    v.flat = pack();
    v.len  = len;
    v.e    = e;
    vecs.push_back(v);
  endtask

  task automatic cmp_out(input string t, input exp_t e);
    chk({t, ".eth_type"}, 64'(eth_type), 64'(e.et));
    chk({t, ".vlan_id"}, 64'(vlan_id), 64'(e.vid));
    chk({t, ".src_ip"}, 64'(src_ip), 64'(e.sip));
    chk({t, ".dst_ip"}, 64'(dst_ip), 64'(e.dip));
    chk({t, ".ip_proto"}, 64'(ip_proto), 64'(e.pr));
    chk({t, ".ports"}, 64'({src_port, dst_port}), 64'({e.sp, e.dp}));
    chk({t, ".pkt_len"}, 64'(pkt_len), 64'(e.pl));
    chk({t, ".flags"}, 64'({is_ipv4, is_l4, csum_ok, malformed}),
        64'({e.v4, e.l4, e.ck, e.mf}));
  endtask

  task automatic run_vec(input string t, input logic [8*HB-1:0] flat, input logic [8:0] len,
                         input exp_t e, input int hold);
    int   cyc;
    bit   got;
    exp_t x;
    @(negedge clk);
    chk({t, ".idle_ready"}, 64'(hdr_ready), 64'(1));
    hdr_flat  = flat;
    hdr_len   = len;
    hdr_valid = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    cyc = 1;
    @(negedge clk);
    hdr_valid = 1'b0;
    hdr_flat  = {48{$urandom()}};
    hdr_len   = 9'($urandom());
    chk({t, ".busy_ready"}, 64'(hdr_ready), 64'(0));
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (parse_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no parse_valid expected one within 40 cycles", t);
      void'(sb.pop_front());
      return;
    end
    x = sb.pop_front();
    chk({t, ".latency"}, 64'(cyc), 64'(x.lat));
    cmp_out(t, x);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({t, ".hold"}, 64'({parse_valid, hdr_ready, src_ip, src_port, csum_ok}),
          64'({1'b1, 1'b0, x.sip, x.sp, x.ck}));
    end
    parse_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    parse_ready = 1'b0;
    chk({t, ".release"}, 64'({parse_valid, hdr_ready}), 64'(2'b01));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e_udp;
    rst_n = 1'b0; hdr_flat = '0; hdr_len = '0; hdr_valid = 1'b0; parse_ready = 1'b0;

    // Vector table
    e_udp = mk_exp(16'h0800, 12'h0, 32'h0a000001, 32'h0a000002, 8'd17, 16'h04D2, 16'h0050,
                   9'd42, 1, 1, 1, 0, 13);
    new_frame(16'h0800); build_ip(14, 8'h45, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd42, e_udp);                                                          // v0
    pb[22] = pb[22] ^ 8'h01;
    add_vec(9'd42, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 17, 16'h04D2, 16'h0050,
                          42, 1, 1, 0, 0, 13));                                     // v1
    new_frame(16'h0806);
    add_vec(9'd60, mk_exp(16'h0806, 0, 0, 0, 0, 0, 0, 60, 0, 0, 0, 0, 2));          // v2
    new_frame(16'h0800); build_ip(14, 8'h45, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd10, mk_exp(0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 2));                 // v3
    new_frame(16'h0800); build_ip(14, 8'h44, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd42, mk_exp(16'h0800, 0, 0, 0, 0, 0, 0, 42, 0, 0, 0, 1, 2));          // v4
    new_frame(16'h8100); put16(14, 16'h0123); put16(16, 16'h0800);
    build_ip(18, 8'h45, 8'd6, 16'h1F90, 16'h01BB);
`ifdef HFE_VLAN_EN
    add_vec(9'd58, mk_exp(16'h0800, 12'h123, 32'h0a000001, 32'h0a000002, 6, 16'h1F90,
                          16'h01BB, 58, 1, 1, 1, 0, 13));                           // v5
`else
    add_vec(9'd58, mk_exp(16'h8100, 0, 0, 0, 0, 0, 0, 58, 0, 0, 0, 0, 2));          // v5
`endif
    new_frame(16'h0800); build_ip(14, 8'h46, 8'd6, 16'h1111, 16'h2222);
    add_vec(9'd40, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 6, 0, 0,
                          40, 1, 0, 1, 0, 15));                                     // v6
    new_frame(16'h0800); build_ip(14, 8'h45, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd30, mk_exp(16'h0800, 0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 1, 2));          // v7
    new_frame(16'h0800); build_ip(14, 8'h65, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd42, mk_exp(16'h0800, 0, 0, 0, 0, 0, 0, 42, 0, 0, 0, 1, 2));          // v8
    new_frame(16'h0800); build_ip(14, 8'h45, 8'd17, 16'h04D2, 16'h0050);
    add_vec(9'd300, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 17, 16'h04D2,
                           16'h0050, 300, 1, 1, 1, 0, 13));                         // v9
    add_vec(9'd38, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 17, 16'h04D2,
                          16'h0050, 38, 1, 1, 1, 0, 13));                           // v10
    add_vec(9'd37, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 17, 0, 0,
                          37, 1, 0, 1, 0, 13));                                     // v11
    new_frame(16'h0800); build_ip(14, 8'h45, 8'd1, 16'h0800, 16'h1234);
    add_vec(9'd42, mk_exp(16'h0800, 0, 32'h0a000001, 32'h0a000002, 1, 0, 0,
                          42, 1, 0, 1, 0, 13));                                     // v12
    new_frame(16'h0806);
    add_vec(9'd14, mk_exp(16'h0806, 0, 0, 0, 0, 0, 0, 14, 0, 0, 0, 0, 2));          // v13
    add_vec(9'd13, mk_exp(0, 0, 0, 0, 0, 0, 0, 13, 0, 0, 0, 1, 2));                 // v14

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.outs_zero", 64'(|{parse_valid, eth_type, vlan_id, src_ip, dst_ip, ip_proto,
                                 src_port, dst_port, pkt_len, is_ipv4, is_l4, csum_ok,
                                 malformed}), 64'(0));
    chk("reset.hdr_ready", 64'(hdr_ready), 64'(1));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("v%0d", i), vecs[i].flat, vecs[i].len, vecs[i].e, (i == 0) ? 5 : 0);

    // Reset pulsed while the checksum is being accumulated
    @(negedge clk);
    hdr_flat = vecs[0].flat; hdr_len = vecs[0].len; hdr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hdr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.pre_src_ip", 64'(src_ip), 64'(32'h0a000001));
    chk("midrst.pre_ready", 64'(hdr_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst.outs_zero", 64'(|{parse_valid, eth_type, vlan_id, src_ip, dst_ip, ip_proto,
                                  src_port, dst_port, pkt_len, is_ipv4, is_l4, csum_ok,
                                  malformed}), 64'(0));
    chk("midrst.hdr_ready", 64'(hdr_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", vecs[2].flat, vecs[2].len, vecs[2].e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
